rgb_channel_splitter: RTL and testbench
=======================================

// Module: rgb_channel_splitter
// PURPOSE
//  Inverse of the RGB merge path: accepts one RGB pixel per handshake and emits it as
//  three sequential single-channel beats (R, then G, then B) on a tagged byte stream.
//  Tracks pixel column/row so each beat carries start-of-frame, end-of-line and
//  end-of-frame flags. Feeds per-channel writers (P2 planes) and serial channel links.
// PARAMETERS
//  DATA_W      8    channel width in bits
//  IMG_WIDTH   640  pixels per line (>=1)
//  IMG_HEIGHT  480  lines per frame (>=1)
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       asynchronous, active-high reset
//  r_in       in   DATA_W  red channel of input pixel
//  g_in       in   DATA_W  green channel of input pixel
//  b_in       in   DATA_W  blue channel of input pixel
//  data_valid in   1       input pixel valid
//  data_ready out  1       block can accept a pixel this cycle
//  ch_data    out  DATA_W  current channel byte
//  ch_id      out  2       0=R, 1=G, 2=B (3 never driven)
//  ch_valid   out  1       ch_data/ch_id/flags valid
//  ch_ready   in   1       downstream accepts current beat
//  ch_sof     out  1       high on R beat of pixel (0,0)
//  ch_eol     out  1       high on B beat of last pixel of a line
//  ch_eof     out  1       high on B beat of last pixel of the frame
//  busy       out  1       a pixel is held (state != IDLE)
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, x=y=0, holding regs 0; outputs
//    ch_valid=0, ch_data=0, ch_id=0, ch_sof/eol/eof=0, busy=0, data_ready=0 while rst high.
//  - Reset mid-pixel discards the held pixel; remaining beats are never emitted.
//  - FSM: IDLE -> EMIT_R -> EMIT_G -> EMIT_B -> (EMIT_R if new pixel taken, else IDLE).
//    EMIT_* advance only on beat handshake (ch_valid && ch_ready); stall otherwise.
//  - data_ready = (state==IDLE) | (state==EMIT_B & ch_ready); combinational from state/ch_ready.
//  - Pixel accept = data_valid & data_ready: r/g/b captured into holding regs on that edge.
//  - Latency: pixel accepted at edge N -> R beat valid from edge N (ch_valid=1 in cycle N+1).
//  - Throughput: 3 cycles/pixel with ch_ready held high; no bubble between B and next R.
//  - ch_data/ch_id are muxed from holding regs by state; held stable while ch_valid & !ch_ready.
//  - Counters: x advances on B-beat handshake; x==IMG_WIDTH-1 wraps to 0 and increments y;
//    y==IMG_HEIGHT-1 with x wrap -> y=0 (next pixel is a new frame).
//  - ch_sof = EMIT_R & x==0 & y==0. ch_eol = EMIT_B & x==IMG_WIDTH-1.
//    ch_eof = EMIT_B & x==IMG_WIDTH-1 & y==IMG_HEIGHT-1. Flags qualify only with ch_valid.
//  - IMG_WIDTH=1: every B beat has ch_eol=1. data_valid while !data_ready: pixel is held by
//    upstream (not captured), inputs may change freely without effect.
//  - Counter widths: $clog2 of parameter (min 1 bit); no arithmetic overflow possible.
// TESTING
//  1 Reset: rst=1 with data_valid=1 -> ch_valid=0, data_ready=0, busy=0; release -> data_ready=1.
//  2 Single pixel (255,128,64), ch_ready=1 -> beats 255/id0, 128/id1, 64/id2 on 3 consecutive
//    cycles starting 1 cycle after accept; then ch_valid=0, busy=0.
//  3 Back-to-back pixels (100,200,50),(0,255,128), ch_ready=1 -> 6 contiguous beats, second
//    pixel accepted in the B cycle of the first, no idle cycle.
//  4 Backpressure: ch_ready=0 for 5 cycles during G beat -> ch_data=G, ch_id=1 held stable,
//    data_ready=0, no beat lost or duplicated.
//  5 Frame flags, IMG_WIDTH=4, IMG_HEIGHT=2, 8 pixels -> ch_sof on beat 0 only, ch_eol on beats
//    11 and 23, ch_eof on beat 23; 9th pixel R beat has ch_sof=1 again.
//  6 Reset asserted during EMIT_G -> ch_valid drops asynchronously, B beat never emitted,
//    next pixel after release carries ch_sof=1.

Source files
------------

// File: rtl/rgb_channel_splitter.sv
// rgb_channel_splitter: serialises one RGB pixel into R, G, B beats
// on a tagged byte stream with start-of-frame / end-of-line / end-of-frame flags.
module rgb_channel_splitter #(
    parameter int DATA_W     = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] r_in,
    input  logic [DATA_W-1:0] g_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [DATA_W-1:0] ch_data,
    output logic [1:0]        ch_id,
    output logic              ch_valid,
    input  logic              ch_ready,
    output logic              ch_sof,
    output logic              ch_eol,
    output logic              ch_eof,
    output logic              busy
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT_R = 2'd1,
        EMIT_G = 2'd2,
        EMIT_B = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] g_q;
    logic [DATA_W-1:0] b_q;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              accept;
    logic              b_done;

    // Handshake qualifiers; ready is forced low while reset is held
    always_comb begin
        data_ready = !rst &&
                     ((state == IDLE) || ((state == EMIT_B) && ch_ready));
        accept     = data_valid && data_ready;
        b_done     = (state == EMIT_B) && ch_ready;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: beats advance only on downstream handshake
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = EMIT_R;
            EMIT_R:  if (ch_ready) state_nxt = EMIT_G;
            EMIT_G:  if (ch_ready) state_nxt = EMIT_B;
            EMIT_B:  if (ch_ready) state_nxt = accept ? EMIT_R : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pixel holding registers, loaded on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            r_q <= r_in;
            g_q <= g_in;
            b_q <= b_in;
        end
    end

    // Column/row position of the pixel currently being emitted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (b_done) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // Output beat: channel mux, tag and frame flags decoded from state
    always_comb begin
        ch_valid = (state != IDLE);
        busy     = (state != IDLE);
        ch_data  = '0;
        ch_id    = 2'd0;
        ch_sof   = 1'b0;
        ch_eol   = 1'b0;
        ch_eof   = 1'b0;
        case (state)
            EMIT_R: begin
                ch_data = r_q;
                ch_id   = 2'd0;
                ch_sof  = (x == '0) && (y == '0);
            end
            EMIT_G: begin
                ch_data = g_q;
                ch_id   = 2'd1;
            end
            EMIT_B: begin
                ch_data = b_q;
                ch_id   = 2'd2;
                ch_eol  = (x == X_LAST);
                ch_eof  = (x == X_LAST) && (y == Y_LAST);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rgb_channel_splitter.sv
// tb_rgb_channel_splitter: directed vector table plus hand-written
// sequences for frame flags and mid-pixel reset, on a 4x2 frame.
module tb_rgb_channel_splitter;

    logic       clk;
    logic       rst;
    logic [7:0] r_in;
    logic [7:0] g_in;
    logic [7:0] b_in;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] ch_data;
    logic [1:0] ch_id;
    logic       ch_valid;
    logic       ch_ready;
    logic       ch_sof;
    logic       ch_eol;
    logic       ch_eof;
    logic       busy;

    int total;
    int bad;

    rgb_channel_splitter #(
        .DATA_W(8),
        .IMG_WIDTH(4),
        .IMG_HEIGHT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .r_in(r_in),
        .g_in(g_in),
        .b_in(b_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .ch_data(ch_data),
        .ch_id(ch_id),
        .ch_valid(ch_valid),
        .ch_ready(ch_ready),
        .ch_sof(ch_sof),
        .ch_eol(ch_eol),
        .ch_eof(ch_eof),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       dv;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       rdy;
        logic       dr;
        logic       cv;
        logic [7:0] d;
        logic [1:0] id;
        logic       sof;
        logic       eol;
        logic       eof;
        logic       busy;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int idx,
                       input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s @%0d: got %0d expected %0d",
                     name, idx, got, exp);
        end
    endtask

    task automatic add(input logic rs, input logic dv,
                       input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic rdy,
                       input logic dr, input logic cv,
                       input logic [7:0] d, input logic [1:0] id,
                       input logic sof, input logic eol,
                       input logic eof, input logic bz);
        vec_t v;
        v.rst = rs;  v.dv = dv;   v.r = r;     v.g = g;
        v.b = b;     v.rdy = rdy; v.dr = dr;   v.cv = cv;
        v.d = d;     v.id = id;   v.sof = sof; v.eol = eol;
        v.eof = eof; v.busy = bz;
        vq.push_back(v);
    endtask

    task automatic check_all(input string tag, input int idx,
                             input vec_t v);
        chk({tag, ".data_ready"}, idx, int'(data_ready), int'(v.dr));
        chk({tag, ".ch_valid"}, idx, int'(ch_valid), int'(v.cv));
        chk({tag, ".ch_data"}, idx, int'(ch_data), int'(v.d));
        chk({tag, ".ch_id"}, idx, int'(ch_id), int'(v.id));
        chk({tag, ".ch_sof"}, idx, int'(ch_sof), int'(v.sof));
        chk({tag, ".ch_eol"}, idx, int'(ch_eol), int'(v.eol));
        chk({tag, ".ch_eof"}, idx, int'(ch_eof), int'(v.eof));
        chk({tag, ".busy"}, idx, int'(busy), int'(v.busy));
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        data_valid = 1'b0;
        ch_ready = 1'b1;
        r_in = '0;
        g_in = '0;
        b_in = '0;

        // Reset with data_valid high, then release
        add(1,1, 1,2,3, 1,  0,0,  0,0, 0,0,0, 0);
        add(0,0, 0,0,0, 1,  1,0,  0,0, 0,0,0, 0);
        // Single pixel (pixel x=0)
        add(0,1, 255,128,64, 1,  1,0,  0,0, 0,0,0, 0);
        add(0,0, 0,0,0, 1,  0,1,  255,0, 1,0,0, 1);
        add(0,0, 0,0,0, 1,  0,1,  128,1, 0,0,0, 1);
        add(0,0, 0,0,0, 1,  1,1,  64,2,  0,0,0, 1);
        // Back-to-back pixels x=1, x=2; second taken in B cycle
        add(0,1, 100,200,50, 1,  1,0,  0,0, 0,0,0, 0);
        add(0,0, 0,0,0, 1,  0,1,  100,0, 0,0,0, 1);
        add(0,0, 0,0,0, 1,  0,1,  200,1, 0,0,0, 1);
        add(0,1, 0,255,128, 1,  1,1,  50,2, 0,0,0, 1);
        add(0,0, 0,0,0, 1,  0,1,  0,0,   0,0,0, 1);
        add(0,0, 0,0,0, 1,  0,1,  255,1, 0,0,0, 1);
        add(0,0, 0,0,0, 1,  1,1,  128,2, 0,0,0, 1);
        // Backpressure on G for 5 cycles; pixel x=3 ends the line
        add(0,1, 10,20,30, 1,  1,0,  0,0, 0,0,0, 0);
        add(0,0, 0,0,0, 1,  0,1,  10,0, 0,0,0, 1);
        add(0,1, 99,98,97, 0,  0,1,  20,1, 0,0,0, 1);
        add(0,1, 91,92,93, 0,  0,1,  20,1, 0,0,0, 1);
        add(0,0, 0,0,0, 0,  0,1,  20,1, 0,0,0, 1);
        add(0,1, 5,6,7, 0,  0,1,  20,1, 0,0,0, 1);
        add(0,0, 0,0,0, 0,  0,1,  20,1, 0,0,0, 1);
        add(0,0, 0,0,0, 1,  0,1,  20,1, 0,0,0, 1);
        add(0,0, 0,0,0, 1,  1,1,  30,2, 0,1,0, 1);
        add(0,0, 0,0,0, 1,  1,0,  0,0,  0,0,0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst;
            data_valid = vq[i].dv;
            r_in = vq[i].r;
            g_in = vq[i].g;
            b_in = vq[i].b;
            ch_ready = vq[i].rdy;
            #1;
            check_all("vec", i, vq[i]);
        end

        // Frame flags: 9 streamed pixels on a fresh 4x2 frame
        begin
            int pin;
            int beat;
            @(negedge clk);
            rst = 1'b1;
            data_valid = 1'b0;
            ch_ready = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            pin = 0;
            beat = 0;
            for (int c = 0; c < 60 && beat < 27; c++) begin
                if (c > 0) @(negedge clk);
                data_valid = (pin < 9);
                r_in = 8'(pin * 3 + 1);
                g_in = 8'(pin * 3 + 2);
                b_in = 8'(pin * 3 + 3);
                #1;
                if (ch_valid && ch_ready) begin
                    chk("frm.data", beat, int'(ch_data), beat + 1);
                    chk("frm.id", beat, int'(ch_id), beat % 3);
                    chk("frm.sof", beat, int'(ch_sof),
                        int'(beat == 0 || beat == 24));
                    chk("frm.eol", beat, int'(ch_eol),
                        int'(beat == 11 || beat == 23));
                    chk("frm.eof", beat, int'(ch_eof),
                        int'(beat == 23));
                    beat++;
                end
                if (data_valid && data_ready) pin++;
            end
            chk("frm.beats", 0, beat, 27);
            @(negedge clk);
            data_valid = 1'b0;
            #1;
            chk("frm.idle", 0, int'(ch_valid), 0);
        end

        // Mid-pixel reset during G; pixel at x=1 so sof is 0 before reset
        begin
            int seen_b;
            @(negedge clk);
            data_valid = 1'b1;
            r_in = 8'd1;
            g_in = 8'd2;
            b_in = 8'd3;
            @(negedge clk);
            data_valid = 1'b0;
            #1;
            chk("rst6.r_sof", 0, int'(ch_sof), 0);
            chk("rst6.r_data", 0, int'(ch_data), 1);
            @(negedge clk);
            #1;
            chk("rst6.g_id", 0, int'(ch_id), 1);
            chk("rst6.g_valid", 0, int'(ch_valid), 1);
            #1;
            rst = 1'b1;
            #1;
            chk("rst6.async_valid", 0, int'(ch_valid), 0);
            chk("rst6.async_busy", 0, int'(busy), 0);
            chk("rst6.async_ready", 0, int'(data_ready), 0);
            @(negedge clk);
            rst = 1'b0;
            seen_b = 0;
            for (int c = 0; c < 3; c++) begin
                #1;
                if (ch_valid) seen_b++;
                @(negedge clk);
            end
            chk("rst6.no_b", 0, seen_b, 0);
            data_valid = 1'b1;
            r_in = 8'd7;
            g_in = 8'd8;
            b_in = 8'd9;
            @(negedge clk);
            data_valid = 1'b0;
            #1;
            chk("rst6.new_valid", 0, int'(ch_valid), 1);
            chk("rst6.new_data", 0, int'(ch_data), 7);
            chk("rst6.new_sof", 0, int'(ch_sof), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
